// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default sizes for the pipeline control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

   // Hazard controller operating states
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } ctrl_state_t;

   localparam int DEF_REG_W   = 5;
   localparam int DEF_TIMEOUT = 16;
   localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard sources from the pipeline and stall/flush/bubble controls back to it.
// Latency: wires only.
// Backpressure: the control outputs are the backpressure into the pipeline registers.
interface hazard_stall_ctrl_if
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_W = DEF_REG_W
) ();

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ready;

   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_stall;
   logic             idex_bubble;
   logic             exmem_stall;

   // Pipeline side: reports hazards, obeys controls
   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             ex_branch_taken, mem_req, mem_ready,
      input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall
   );

   // Controller side
   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             ex_branch_taken, mem_req, mem_ready,
      output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects inc one clock later.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Increment until every bit is set, then hold so the value never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze with sticky timeout.
// Latency: controls are combinational (0 cycles); mem_timeout and statistics are registered.
// Backpressure: freezes PC, IF/ID, ID/EX and EX/MEM while a data access is outstanding or in ERROR.
module hazard_stall_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_W   = DEF_REG_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_stall_ctrl_if.slave  hz,
   output logic                mem_timeout,
   output logic [CNT_W-1:0]    stall_cycles,
   output logic [CNT_W-1:0]    flush_count
);

   localparam int WCW = $clog2(TIMEOUT + 1);
   // Value of the wait counter on the last not-ready cycle before timing out
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   ctrl_state_t      state, state_nxt;
   logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;

   logic [REG_W-1:0] id_rs, id_rt, ex_rd;
   logic             load_use, mem_busy, freeze;
   logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall;

   assign id_rs = hz.id_rs;
   assign id_rt = hz.id_rt;
   assign ex_rd = hz.ex_rd;

   // R0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = hz.ex_mem_read && (ex_rd != '0) &&
                     ((hz.id_uses_rs && (id_rs == ex_rd)) ||
                      (hz.id_uses_rt && (id_rt == ex_rd)));
   assign mem_busy = hz.mem_req && !hz.mem_ready;
   assign freeze   = (state == ERROR) || mem_busy;

   // Control priority: freeze, then branch squash, then load-use interlock
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_bubble = 1'b0;
      exmem_stall = 1'b0;
      if (freeze) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
      end else if (hz.ex_branch_taken) begin
         // The ID instruction is squashed, so its load-use dependency is moot
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   assign hz.pc_stall    = pc_stall;
   assign hz.ifid_stall  = ifid_stall;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_stall  = idex_stall;
   assign hz.idex_bubble = idex_bubble;
   assign hz.exmem_stall = exmem_stall;

   // Next state and wait-counter update; the entering RUN cycle counts as the first low cycle
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         RUN: begin
            if (mem_busy) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WCW'(1);
            end
         end
         MEM_WAIT: begin
            if (!hz.mem_req || hz.mem_ready) begin
               // Completion or abort: release without error
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt >= WAIT_LAST) begin
               state_nxt    = ERROR;
               wait_cnt_nxt = wait_cnt + 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         ERROR: begin
            state_nxt = ERROR;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // State register with the error flag kept as a flopped decode of the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= (state_nxt == ERROR);
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pc_stall),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ifid_flush),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed expectations.
// Latency: checks controls within the cycle, registered outputs after the next edge.
// Backpressure: n/a.
module tb_hazard_stall_ctrl;
   import cpu_ctrl_pkg::*;

   // Control word order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall
   localparam logic [5:0] C_NONE   = 6'b000000;
   localparam logic [5:0] C_LDUSE  = 6'b110010;
   localparam logic [5:0] C_BRANCH = 6'b001010;
   localparam logic [5:0] C_FREEZE = 6'b110101;

   logic       clk;
   logic       rst_n;
   logic       mem_timeout;
   logic [3:0] stall_cycles;
   logic [3:0] flush_count;

   int n_chk  = 0;
   int n_fail = 0;

   hazard_stall_ctrl_if #(.REG_W(5)) hif ();

   hazard_stall_ctrl #(.REG_W(5), .TIMEOUT(16), .CNT_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hz           (hif.slave),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ctl();
      return {26'd0, hif.pc_stall, hif.ifid_stall, hif.ifid_flush,
              hif.idex_stall, hif.idex_bubble, hif.exmem_stall};
   endfunction

   task automatic quiet();
      hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b0;
      hif.ex_mem_read = 1'b0; hif.ex_rd = '0; hif.ex_branch_taken = 1'b0;
      hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
   endtask

   // Advance one clock, leaving time 1 unit after the edge for new stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      quiet();
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic set_load_use();
      hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_rs = 5'd5; hif.id_uses_rs = 1'b1;
   endtask

   initial begin
      quiet();
      rst_n = 1'b0;
      #2;
      check("reset_ctl", ctl(), C_NONE);
      check("reset_timeout", {31'd0, mem_timeout}, 0);
      check("reset_stall_cnt", {28'd0, stall_cycles}, 0);
      check("reset_flush_cnt", {28'd0, flush_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Load-use: one-cycle interlock
      set_load_use(); #1;
      check("lduse_ctl", ctl(), C_LDUSE);
      step(); quiet(); #1;
      check("lduse_release", ctl(), C_NONE);
      check("lduse_stall_cnt", {28'd0, stall_cycles}, 1);

      // R0 never hazards; unused rt never hazards; used rt does
      hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd0; hif.id_rs = 5'd0; hif.id_uses_rs = 1'b1; #1;
      check("r0_ctl", ctl(), C_NONE);
      quiet(); hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd7; hif.id_rt = 5'd7; #1;
      check("unused_rt_ctl", ctl(), C_NONE);
      hif.id_uses_rt = 1'b1; #1;
      check("used_rt_ctl", ctl(), C_LDUSE);
      hif.ex_mem_read = 1'b0; #1;
      check("no_load_ctl", ctl(), C_NONE);
      quiet();
      step();
      check("r0_stall_cnt", {28'd0, stall_cycles}, 1);

      // Branch overrides load-use
      set_load_use(); hif.ex_branch_taken = 1'b1; #1;
      check("branch_ctl", ctl(), C_BRANCH);
      step(); quiet(); #1;
      check("branch_release", ctl(), C_NONE);
      check("branch_flush_cnt", {28'd0, flush_count}, 1);
      check("branch_stall_cnt", {28'd0, stall_cycles}, 1);

      // Memory wait: three not-ready cycles, then ready
      do_reset();
      hif.mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("memwait_ctl%0d", i), ctl(), C_FREEZE);
         step();
      end
      hif.mem_ready = 1'b1; #1;
      check("memwait_ready_ctl", ctl(), C_NONE);
      step(); quiet(); #1;
      check("memwait_stall_cnt", {28'd0, stall_cycles}, 3);
      check("memwait_no_err", {31'd0, mem_timeout}, 0);
      // Back in RUN: a load-use now interlocks normally
      set_load_use(); #1;
      check("memwait_run_lduse", ctl(), C_LDUSE);
      quiet();

      // Ready and branch in the same cycle: release and flush together
      do_reset();
      hif.mem_req = 1'b1; step();
      hif.mem_ready = 1'b1; hif.ex_branch_taken = 1'b1; #1;
      check("ready_branch_ctl", ctl(), C_BRANCH);
      step(); quiet(); #1;
      check("ready_branch_flush_cnt", {28'd0, flush_count}, 1);

      // Abort: mem_req falls in MEM_WAIT, no error, controller runs again
      do_reset();
      hif.mem_req = 1'b1; step(); step();
      hif.mem_req = 1'b0; #1;
      check("abort_ctl", ctl(), C_NONE);
      step(); #1;
      check("abort_no_err", {31'd0, mem_timeout}, 0);

      // Ready arriving on the sixteenth cycle after fifteen low cycles: no error
      do_reset();
      hif.mem_req = 1'b1;
      for (int i = 0; i < 15; i++) step();
      hif.mem_ready = 1'b1; #1;
      check("edge_ready_ctl", ctl(), C_NONE);
      step(); #1;
      check("edge_ready_no_err", {31'd0, mem_timeout}, 0);
      quiet();

      // Timeout after sixteen low cycles, sticky through mem_ready
      do_reset();
      hif.mem_req = 1'b1;
      for (int i = 0; i < 15; i++) step();
      check("timeout_not_yet", {31'd0, mem_timeout}, 0);
      step();
      check("timeout_set", {31'd0, mem_timeout}, 1);
      hif.mem_ready = 1'b1; #1;
      check("error_ctl_ready", ctl(), C_FREEZE);
      hif.mem_req = 1'b0; hif.mem_ready = 1'b0; hif.ex_branch_taken = 1'b1; #1;
      check("error_ctl_branch", ctl(), C_FREEZE);
      step();
      check("timeout_sticky", {31'd0, mem_timeout}, 1);
      check("timeout_stall_sat", {28'd0, stall_cycles}, 15);
      quiet();
      rst_n = 1'b0; #1;
      check("rst_clears_err", {31'd0, mem_timeout}, 0);
      check("rst_clears_stall", {28'd0, stall_cycles}, 0);
      check("rst_clears_flush", {28'd0, flush_count}, 0);
      check("rst_ctl", ctl(), C_NONE);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Saturation with a 4-bit counter
      set_load_use();
      for (int i = 0; i < 20; i++) step();
      check("sat_stall_cnt", {28'd0, stall_cycles}, 15);
      step();
      check("sat_stall_hold", {28'd0, stall_cycles}, 15);
      quiet();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
